// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one iteration per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies complete at accept.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [W-1:0]           opnd_q;
  logic [2*W-1:0]         acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   neg_a_q;
  logic                   neg_b_q;
  logic                   b_zero_q;

  // Accept-time operand decode
  logic         a_signed_in, b_signed_in, neg_a_in, neg_b_in;
  logic [W-1:0] mag_a_in, mag_b_in;

  always_comb begin
    a_signed_in = Operation[2] ? !Operation[0] : (Operation[1:0] != 2'b11);
    b_signed_in = Operation[2] ? !Operation[0] : !Operation[1];
    neg_a_in    = a_signed_in & SrcA[W-1];
    neg_b_in    = b_signed_in & SrcB[W-1];
    mag_a_in    = neg_a_in ? ('0 - SrcA) : SrcA;
    mag_b_in    = neg_b_in ? ('0 - SrcB) : SrcB;
  end

  logic         skip;
  logic [W-1:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
  logic div0_in, ovf_in, mul0_in;
  always_comb begin
    div0_in   = Operation[2] & (SrcB == '0);
    ovf_in    = Operation[2] & !Operation[0] & (SrcA == MOST_NEG) & (SrcB == '1);
    mul0_in   = !Operation[2] & ((SrcA == '0) | (SrcB == '0));
    skip      = div0_in | ovf_in | mul0_in;
    early_res = '0;
    if (div0_in)
      early_res = Operation[1] ? SrcA : '1;
    else if (ovf_in)
      early_res = Operation[1] ? '0 : MOST_NEG;
  end
`else
  always_comb begin
    skip      = 1'b0;
    early_res = '0;
  end
`endif

  // One iteration: multiply keeps {partial product, remaining multiplier bits};
  // divide keeps {partial remainder, remaining dividend bits / quotient bits}.
  logic [W:0]     mul_sum;
  logic [W:0]     rem_shift;
  logic           rem_ge;
  logic [W-1:0]   rem_diff, rem_new;
  logic [2*W-1:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_diff  = rem_shift[W-1:0] - opnd_q;
    rem_new   = rem_ge ? rem_diff : rem_shift[W-1:0];
    if (op_q[2])
      acc_next = {rem_new, acc_q[W-2:0], rem_ge};
    else
      acc_next = {mul_sum, acc_q[W-1:1]};
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fin_result;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? ('0 - acc_next) : acc_next;
    // A zero divisor leaves an all-ones quotient, which must not be negated
    quo_fix  = ((neg_a_q ^ neg_b_q) && !b_zero_q) ? ('0 - acc_next[W-1:0]) : acc_next[W-1:0];
    rem_fix  = neg_a_q ? ('0 - acc_next[2*W-1:W]) : acc_next[2*W-1:W];
    if (op_q[2])
      fin_result = op_q[1] ? rem_fix : quo_fix;
    else
      fin_result = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= Operation;
            neg_a_q  <= neg_a_in;
            neg_b_q  <= neg_b_in;
            b_zero_q <= (SrcB == '0);
            opnd_q   <= Operation[2] ? mag_b_in : mag_a_in;
            acc_q    <= {{W{1'b0}}, (Operation[2] ? mag_a_in : mag_b_in)};
            cnt_q    <= CW'(W - 1);
            busy     <= 1'b1;
            if (skip) begin
              state  <= DONE;
              done   <= 1'b1;
              Result <= early_res;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state  <= DONE;
            done   <= 1'b1;
            Result <= fin_result;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
